// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Shares the single register-file write port (WE3/A3/WD3) among NUM_REQ
// writeback requesters with a valid/ready handshake and round-robin
// arbitration. Writes reach the register file one cycle after the handshake
// through a registered output stage. A clear sequencer can take over the port
// on command and write zero to registers 1..31 in order.
//
// Ports:
//   clk, rst        clock (rising edge) and asynchronous active-low reset
//   req_valid       per-requester write request
//   req_addr        flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data        flattened data, requester i at [i*DATA_W +: DATA_W]
//   req_ready       one-hot grant (combinational)
//   clear_req       pulse that starts the clear sequence
//   clear_busy      high while the clear sequence owns the port
//   clear_done      one-cycle pulse alongside the final (address 31) write
//   rf_we/a3/wd3    register-file write port (registered)
//   grant_id        requester behind the current rf_we cycle (0 for clears)
//
// Optional feature, enabled by defining REGFILE_ARB_STALL_CNT_EN:
//   stall_clr       synchronous clear of stall_count (wins over increment)
//   stall_count     saturating count of idle-state cycles in which some
//                   requester is valid but not granted
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clear_req,
    output logic                      clear_busy,
    output logic                      clear_done,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_a3,
    output logic [DATA_W-1:0]         rf_wd3,
    output logic [2:0]                grant_id
`ifdef REGFILE_ARB_STALL_CNT_EN
    ,
    input  logic                      stall_clr,
    output logic [15:0]               stall_count
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] CLEAR_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CLEAR_LAST  = ADDR_W'(31);

    state_t              state_q,     state_d;
    logic [2:0]          rr_ptr_q,    rr_ptr_d;
    logic [ADDR_W-1:0]   clear_idx_q, clear_idx_d;
    logic                rf_we_q,     rf_we_d;
    logic [ADDR_W-1:0]   rf_a3_q,     rf_a3_d;
    logic [DATA_W-1:0]   rf_wd3_q,    rf_wd3_d;
    logic [2:0]          grant_id_q,  grant_id_d;
    logic                clear_done_q, clear_done_d;

    logic [7:0]          valid_ext_s;
    logic [3:0]          cand_s;
    logic                grant_found_s;
    logic [2:0]          grant_idx_s;
    logic                arb_en_s;
    logic                accept_s;
    logic [NUM_REQ-1:0]  ready_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic [3:0]          ptr_inc_s;
    logic [2:0]          ptr_next_s;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        valid_ext_s                = 8'h00;
        valid_ext_s[NUM_REQ-1:0]   = req_valid;
        grant_found_s              = 1'b0;
        grant_idx_s                = 3'd0;
        cand_s                     = 4'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s = {1'b0, rr_ptr_q} + 4'(k);
            if (cand_s >= 4'(NUM_REQ)) begin
                cand_s = cand_s - 4'(NUM_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!grant_found_s && valid_ext_s[cand_s[2:0]]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s[2:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant is only offered in IDLE, out of reset, and when no clear is
    // being requested this cycle (the clear request wins the port).
    always_comb begin
        arb_en_s = rst && (state_q == ST_IDLE) && !clear_req;
        accept_s = arb_en_s && grant_found_s;
        ready_s  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept_s && (grant_idx_s == 3'(i))) begin
                ready_s[i] = 1'b1;
            end else begin
                ready_s[i] = 1'b0;
            end
        end
    end

    // Select the winning requester's address/data with constant part-selects.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_s == 3'(i)) begin
                sel_addr_s = req_addr[i*ADDR_W +: ADDR_W];
                sel_data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                sel_addr_s = sel_addr_s;
                sel_data_s = sel_data_s;
            end
        end
    end

    // Pointer moves to the requester just after the winner, modulo NUM_REQ.
    always_comb begin
        ptr_inc_s = {1'b0, grant_idx_s} + 4'd1;
        if (ptr_inc_s >= 4'(NUM_REQ)) begin
            ptr_next_s = 3'd0;
        end else begin
            ptr_next_s = ptr_inc_s[2:0];
        end
    end

    // FSM next-state and registered-output next values.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        clear_idx_d  = clear_idx_q;
        rf_we_d      = 1'b0;
        rf_a3_d      = rf_a3_q;
        rf_wd3_d     = rf_wd3_q;
        grant_id_d   = grant_id_q;
        clear_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (accept_s) begin
                    rf_a3_d    = sel_addr_s;
                    rf_wd3_d   = sel_data_s;
                    grant_id_d = grant_idx_s;
                    rr_ptr_d   = ptr_next_s;
                    // x0 is hardwired to zero: complete the handshake but
                    // never assert the write enable for it.
                    rf_we_d    = (sel_addr_s != '0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                rf_we_d    = 1'b1;
                rf_a3_d    = clear_idx_q;
                rf_wd3_d   = '0;
                grant_id_d = 3'd0;
                if (clear_idx_q == CLEAR_LAST) begin
                    // Leave CLEAR as the last write is issued so clear_done
                    // lines up with the address-31 rf_we cycle.
                    state_d      = ST_IDLE;
                    clear_idx_d  = CLEAR_FIRST;
                    clear_done_d = 1'b1;
                end else begin
                    clear_idx_d = clear_idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d     = ST_IDLE;
                clear_idx_d = CLEAR_FIRST;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= 3'd0;
            clear_idx_q  <= CLEAR_FIRST;
            rf_we_q      <= 1'b0;
            rf_a3_q      <= '0;
            rf_wd3_q     <= '0;
            grant_id_q   <= 3'd0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            clear_idx_q  <= clear_idx_d;
            rf_we_q      <= rf_we_d;
            rf_a3_q      <= rf_a3_d;
            rf_wd3_q     <= rf_wd3_d;
            grant_id_q   <= grant_id_d;
            clear_done_q <= clear_done_d;
        end
    end

    assign req_ready  = ready_s;
    assign clear_busy = (state_q == ST_CLEAR);
    assign clear_done = clear_done_q;
    assign rf_we      = rf_we_q;
    assign rf_a3      = rf_a3_q;
    assign rf_wd3     = rf_wd3_q;
    assign grant_id   = grant_id_q;

`ifdef REGFILE_ARB_STALL_CNT_EN
    logic [15:0] stall_count_q, stall_count_d;
    logic        stall_event_s;

    // A stall is any idle-state cycle with a valid requester left ungranted.
    always_comb begin
        stall_event_s = (state_q == ST_IDLE) && (|(req_valid & ~ready_s));
        if (stall_clr) begin
            stall_count_d = 16'h0000;
        end else if (stall_event_s && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'h0001;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= 16'h0000;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// Self-checking bench for regfile_write_arbiter (NUM_REQ=3, ADDR_W=5,
// DATA_W=32). Each cycle the stimulus task drives the inputs, checks the
// combinational grant against a behavioural model, and pushes the expected
// registered outputs for the next edge onto a scoreboard queue; a negedge
// monitor pops and compares them.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid = 3'b000;
    logic [14:0] req_addr  = 15'd0;
    logic [95:0] req_data  = 96'd0;
    logic [2:0]  req_ready;
    logic        clear_req = 1'b0;
    logic        clear_busy;
    logic        clear_done;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;
    logic [2:0]  grant_id;
`ifdef REGFILE_ARB_STALL_CNT_EN
    logic        stall_clr = 1'b0;
    logic [15:0] stall_count;
`endif

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NUM_REQ(3), .ADDR_W(5), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .rf_we      (rf_we),
        .rf_a3      (rf_a3),
        .rf_wd3     (rf_wd3),
        .grant_id   (grant_id)
`ifdef REGFILE_ARB_STALL_CNT_EN
        ,
        .stall_clr  (stall_clr),
        .stall_count(stall_count)
`endif
    );

    typedef struct packed {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd3;
        logic [2:0]  gid;
        logic        done;
        logic        busy;
        int          due;
    } exp_t;

    exp_t sb_q[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Behavioural model state
    int          m_ptr;
    bit          m_clear;
    int          m_idx;
    logic [4:0]  m_a3;
    logic [31:0] m_wd3;
    logic [2:0]  m_gid;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_clear = 1'b0;
        m_idx   = 1;
        m_a3    = 5'd0;
        m_wd3   = 32'd0;
        m_gid   = 3'd0;
        sb_q.delete();
    endtask

    // One clock cycle of stimulus plus model update.
    task automatic cycle(input logic [2:0] v, input logic [14:0] a, input logic [95:0] d,
                         input logic clr, output logic [2:0] exp_rdy);
        exp_t e;
        int   win;
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr  = a;
        req_data  = d;
        clear_req = clr;
        #2;
        exp_rdy = 3'b000;
        win     = -1;
        e.we    = 1'b0;
        e.done  = 1'b0;
        if (!m_clear) begin
            if (clr) begin
                m_clear = 1'b1;
            end else begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (m_ptr + k) % 3;
                    if (win < 0 && v[i]) win = i;
                end
                if (win >= 0) begin
                    exp_rdy[win] = 1'b1;
                    m_a3  = a[win*5 +: 5];
                    m_wd3 = d[win*32 +: 32];
                    m_gid = 3'(win);
                    e.we  = (m_a3 != 5'd0);
                    m_ptr = (win + 1) % 3;
                end
            end
        end else begin
            e.we  = 1'b1;
            m_a3  = 5'(m_idx);
            m_wd3 = 32'd0;
            m_gid = 3'd0;
            if (m_idx == 31) begin
                m_idx   = 1;
                m_clear = 1'b0;
                e.done  = 1'b1;
            end else begin
                m_idx++;
            end
        end
        e.a3   = m_a3;
        e.wd3  = m_wd3;
        e.gid  = m_gid;
        e.busy = m_clear;
        e.due  = cyc + 1;
        check_val("req_ready", 64'(req_ready), 64'(exp_rdy));
        sb_q.push_back(e);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Compare registered outputs against the scoreboard after each edge.
    always @(negedge clk) begin
        if (rst && sb_q.size() > 0 && sb_q[0].due == cyc) begin
            exp_t e;
            e = sb_q.pop_front();
            check_val("rf_we",      64'(rf_we),      64'(e.we));
            check_val("rf_a3",      64'(rf_a3),      64'(e.a3));
            check_val("rf_wd3",     64'(rf_wd3),     64'(e.wd3));
            check_val("grant_id",   64'(grant_id),   64'(e.gid));
            check_val("clear_done", 64'(clear_done), 64'(e.done));
            check_val("clear_busy", 64'(clear_busy), 64'(e.busy));
        end
    end

    function automatic logic [14:0] pk_a(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
        return {a2, a1, a0};
    endfunction

    function automatic logic [95:0] pk_d(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        return {d2, d1, d0};
    endfunction

    initial begin
        logic [2:0] rdy;
        logic [2:0] v;
        int         zeros;
        bit         granted;
        int         done_cnt;

        // Reset: outputs at reset values, no grant even with requests pending
        model_reset();
        req_valid = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_ready", 64'(req_ready),  64'(3'b000));
        check_val("rst_we",    64'(rf_we),      64'(1'b0));
        check_val("rst_a3",    64'(rf_a3),      64'(5'd0));
        check_val("rst_wd3",   64'(rf_wd3),     64'(32'd0));
        check_val("rst_gid",   64'(grant_id),   64'(3'd0));
        check_val("rst_busy",  64'(clear_busy), 64'(1'b0));
        check_val("rst_done",  64'(clear_done), 64'(1'b0));
`ifdef REGFILE_ARB_STALL_CNT_EN
        check_val("rst_stall", 64'(stall_count), 64'(16'd0));
`endif
        req_valid = 3'b000;
        rst = 1'b1;

        // Single request from requester 0
        cycle(3'b001, pk_a(5'd5, 5'd0, 5'd0), pk_d(32'hDEAD_BEEF, 32'd0, 32'd0), 1'b0, rdy);
        check_val("single_ready", 64'(req_ready), 64'(3'b001));
        // Lone requester 2 moves the pointer back to 0
        cycle(3'b100, pk_a(5'd0, 5'd0, 5'd3), pk_d(32'd0, 32'd0, 32'h2222_0002), 1'b0, rdy);
        cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);

        // Round-robin with all requesters continuously valid
        for (int k = 0; k < 6; k++) begin
            cycle(3'b111, pk_a(5'(10 + k), 5'(20 + k), 5'(28 - k)),
                  pk_d(32'hA000_0000 + 32'(k), 32'hB000_0000 + 32'(k), 32'hC000_0000 + 32'(k)),
                  1'b0, rdy);
            check_val("rr_order", 64'(req_ready), 64'(3'b001 << (k % 3)));
        end
        cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);

        // x0 write from requester 1: handshake completes, no rf_we
        cycle(3'b010, pk_a(5'd0, 5'd0, 5'd0), pk_d(32'd0, 32'h0000_1234, 32'd0), 1'b0, rdy);
        check_val("x0_ready", 64'(req_ready), 64'(3'b010));
        cycle(3'b111, pk_a(5'd1, 5'd2, 5'd4), pk_d(32'h11, 32'h22, 32'h44), 1'b0, rdy);
        check_val("x0_then_rr", 64'(req_ready), 64'(3'b100));
        cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);

        // Clear sequence started alongside a pending request from requester 1
        zeros    = 0;
        granted  = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            v = granted ? 3'b000 : 3'b010;
            // a second clear_req mid-sequence must be ignored
            cycle(v, pk_a(5'd0, 5'd7, 5'd0), pk_d(32'd0, 32'h7777_0007, 32'd0),
                  (k == 0 || k == 5) ? 1'b1 : 1'b0, rdy);
            if (clear_done) done_cnt++;
            if (!granted) begin
                if (req_ready == 3'b000) begin
                    zeros++;
                end else begin
                    granted = 1'b1;
                    check_val("clr_first_grant", 64'(req_ready), 64'(3'b010));
                end
            end
        end
        check_val("clr_ready_zero_cycles", 64'(zeros), 64'(32));
        check_val("clr_done_pulses", 64'(done_cnt), 64'(1));

        // Reset in the middle of a clear
        cycle(3'b000, 15'd0, 96'd0, 1'b1, rdy);
        for (int k = 0; k < 10; k++) cycle(3'b010, pk_a(5'd0, 5'd9, 5'd0), 96'd0, 1'b0, rdy);
        @(posedge clk);
        #1;
        check_val("mid_a3", 64'(rf_a3), 64'(5'd10));
        rst = 1'b0;
        #1;
        check_val("mid_rst_we",    64'(rf_we),      64'(1'b0));
        check_val("mid_rst_busy",  64'(clear_busy), 64'(1'b0));
        check_val("mid_rst_ready", 64'(req_ready),  64'(3'b000));
        model_reset();
        req_valid = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        // No leftover clear writes after release
        for (int k = 0; k < 35; k++) cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);

`ifdef REGFILE_ARB_STALL_CNT_EN
        check_val("stall_start", 64'(stall_count), 64'(16'd0));
        v = 3'b011;
        for (int k = 0; k < 4; k++) begin
            cycle(v, pk_a(5'd12, 5'd13, 5'd0), pk_d(32'h0C, 32'h0D, 32'd0), 1'b0, rdy);
            v = v & ~rdy;
        end
        cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);
        check_val("stall_count", 64'(stall_count), 64'(16'd1));
        stall_clr = 1'b1;
        cycle(3'b000, 15'd0, 96'd0, 1'b0, rdy);
        stall_clr = 1'b0;
        check_val("stall_clr", 64'(stall_count), 64'(16'd0));
`endif

        // Drain the last scoreboard entry
        @(posedge clk);
        @(negedge clk);
        #1;
        check_val("sb_drained", 64'(sb_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3) among NUM_REQ writeback requesters, e.g. ALU, load unit, debug.
- Uses a valid/ready handshake with round-robin arbitration and a registered one-cycle output stage.
- Contains a clear sequencer that zeroes registers 1..31 through the same port on command.
- Sits between the writeback sources and the register file.

Parameters:
- NUM_REQ, 3, number of requesters (legal range 2..8).
- ADDR_W, 5, register address width.
- DATA_W, 32, write data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-low (asserted when 0).
- req_valid  input  NUM_REQ  per-requester write request.
- req_addr  input  NUM_REQ*ADDR_W  flattened destination addresses; requester i occupies bits [i*ADDR_W +: ADDR_W].
- req_data  input  NUM_REQ*DATA_W  flattened write data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant, combinational.
- clear_req  input  1  pulse that starts the clear sequence.
- clear_busy  output  1  high while in CLEAR.
- clear_done  output  1  one-cycle pulse when the clear sequence finishes.
- rf_we  output  1  register-file write enable.
- rf_a3  output  ADDR_W  register-file write address.
- rf_wd3  output  DATA_W  register-file write data.
- grant_id  output  3  index of the requester behind the current rf_we cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, rr_ptr=0, clear_idx=1.
  - rf_we=0, rf_a3=0, rf_wd3=0, grant_id=0, clear_busy=0, clear_done=0.
  - req_ready=0 while rst=0.
- States: IDLE (arbitrate), CLEAR (sequence zero writes).
- IDLE arbitration:
  - Search starts at rr_ptr and wraps modulo NUM_REQ; the first i with req_valid[i]=1 gets req_ready[i]=1, all other ready bits 0, in the same cycle.
  - No valid requests: req_ready=0.
  - Accept = req_valid[i] & req_ready[i].
  - On accept, at the next edge: rf_a3=req_addr[i], rf_wd3=req_data[i], grant_id=i, rr_ptr=(i+1) mod NUM_REQ.
  - rf_we=1 on that edge unless req_addr[i]==0.
- Latency: exactly 1 cycle from accept to rf_we. Sustained throughput is 1 write per cycle.
- Output hold: with no accept, rf_we=0 next cycle; rf_a3, rf_wd3 and grant_id hold their last values.
- Writes to x0: the handshake completes (ready=1), rr_ptr advances, rf_we stays 0.
- Requesters must hold valid/addr/data stable until accepted. The block holds no per-requester buffer.
- IDLE to CLEAR: clear_req=1 in IDLE enters CLEAR at the next edge.
  - clear_req beats any pending request in that cycle: req_ready=0, no accept.
- CLEAR:
  - req_ready=0, clear_busy=1.
  - Each cycle drives rf_we=1, rf_a3=clear_idx, rf_wd3=0, grant_id=0 (registered outputs, one-cycle latency), then increments clear_idx.
  - 31 write cycles, addresses 1..31 in order.
  - After the clear_idx=31 write is issued: return to IDLE, clear_done=1 for exactly one cycle (coincident with the address-31 rf_we), clear_idx reset to 1.
  - rr_ptr is unchanged by the clear.
- clear_req during CLEAR is ignored; it does not restart or extend the sequence.
- Reset asserted mid-clear: immediate IDLE with reset values; a partial clear is not resumed.
- clear_done=0 in all other cycles.

Optional Feature:
- Macro REGFILE_ARB_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [15:0], reset 0.
  - In IDLE, stall_count increments every cycle in which some requester has req_valid=1 and req_ready=0.
  - Saturates at 16'hFFFF.
  - Also adds input stall_clr [1], which zeroes the count synchronously and has priority over increment.
- Not defined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then single request: hold rst=0 for 2 cycles, release; req_valid=3'b001, addr=5, data=32'hDEAD_BEEF.
  - Required: req_ready=3'b001 the same cycle; next cycle rf_we=1, rf_a3=5, rf_wd3=DEADBEEF, grant_id=0.
- Round-robin: req_valid=3'b111 held for 6 cycles, each requester re-presenting after accept.
  - Required: grant order 0,1,2,0,1,2; rf_we=1 on 6 consecutive cycles.
- x0 write: requester 1 addr=0, data=32'h1234.
  - Required: req_ready[1]=1; next cycle rf_we=0; rr_ptr advances, so the next simultaneous 3'b111 grants requester 2.
- Clear sequence: clear_req=1 with req_valid=3'b010 in the same cycle.
  - Required: req_ready=0 for 32 cycles.
  - rf_we=1 with rf_a3 running 1..31 and rf_wd3=0.
  - clear_done pulses once with rf_a3=31; requester 1 is granted the cycle after return to IDLE.
- Reset mid-clear: assert rst=0 when rf_a3=10.
  - Required: rf_we=0, clear_busy=0 immediately; after release, state is IDLE and no further clear writes occur.
- With REGFILE_ARB_STALL_CNT_EN: req_valid=3'b011 for 4 cycles, each request dropped after its accept.
  - Required: stall_count=1 (requester 1 waiting in cycle 1 only).
  - stall_clr=1 gives 0 the next cycle.
